// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the PM fetch controller.
//   - opcode constants for the instructions the fetch sequencer acts on
//   - instruction field bit positions (opcode, immediate)
//   - fetch FSM state encoding (2 bits)
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_HLT = 6'h3F;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_op_decode.sv
// fetch_op_decode: combinational classification of the fetched instruction.
// Ports:
//   ins             in  32  instruction from program memory
//   current_address in  16  address of ins
//   is_jump         out 1   opcode is J or JAL
//   is_branch       out 1   opcode is BEQ or BNE
//   is_halt         out 1   opcode is HLT
//   target          out 16  jump: imm; branch: current_address + 1 + imm (mod 2^16)
module fetch_op_decode
  import mips_pkg::*;
(
  input  logic [31:0] ins,
  input  logic [15:0] current_address,
  output logic        is_jump,
  output logic        is_branch,
  output logic        is_halt,
  output logic [15:0] target
);

  logic [5:0]  opcode;
  logic [15:0] imm;
  logic        unused_fields;

  assign opcode = ins[OPCODE_MSB:OPCODE_LSB];
  assign imm    = ins[IMM_MSB:IMM_LSB];
  // Register fields are not needed by the fetch sequencer.
  assign unused_fields = ^ins[25:16];

  assign is_jump   = (opcode == OP_J)   || (opcode == OP_JAL);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_halt   = (opcode == OP_HLT);
  // 16-bit add wraps naturally at the top of the address space.
  assign target    = is_branch ? (current_address + 16'd1 + imm) : imm;

endmodule

// File: rtl/pm_fetch_controller.sv
// pm_fetch_controller: fetch sequencer for program_memory_block.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   ins, current_address  fetched instruction and its address
//   ext_stall         hazard-unit stall request (beats decode in RUN)
//   br_resolved, br_taken  branch result from execute
//   run               single-cycle pulse that leaves HALT
//   jmp_loc, pc_mux_sel    redirect target / PC load select to the PM block
//   stall, stall_pm   freeze PC / freeze PM output register
//   flush             squash the decode-stage instruction
//   halted            HALT state indicator
//   br_timeout_err    sticky branch-timeout flag
//   redirect_cnt      saturating count of taken redirects
//   state_dbg         current FSM state (debug)
//
// Branch handshake: br_taken is meaningful only in a cycle where
// br_resolved=1; br_resolved is a single-cycle valid with no ready, so the
// controller consumes it in the cycle it is seen while in BR_WAIT and
// ignores it in every other state.
//
// Control outputs are a function of the current state and inputs so that a
// redirect or stall takes effect in the same cycle the instruction is seen.
module pm_fetch_controller
  import mips_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          BR_TIMEOUT   = 8,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic [15:0]      current_address,
  input  logic             ext_stall,
  input  logic             br_resolved,
  input  logic             br_taken,
  input  logic             run,
  output logic [15:0]      jmp_loc,
  output logic             pc_mux_sel,
  output logic             stall,
  output logic             stall_pm,
  output logic             flush,
  output logic             halted,
  output logic             br_timeout_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       state_dbg
);

  localparam int TO_W = $clog2(BR_TIMEOUT + 1);

  fetch_state_t     state, next_state;
  logic             boot_q;          // first cycle after reset: load RESET_VECTOR
  logic [15:0]      jmp_loc_q;       // jmp_loc holds its last value between redirects
  logic [15:0]      br_target_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] redirect_cnt_q;

  logic        dec_is_jump, dec_is_branch, dec_is_halt;
  logic [15:0] dec_target;
  logic        do_redirect, do_capture, do_timeout;

  fetch_op_decode u_decode (
    .ins             (ins),
    .current_address (current_address),
    .is_jump         (dec_is_jump),
    .is_branch       (dec_is_branch),
    .is_halt         (dec_is_halt),
    .target          (dec_target)
  );

  always_comb begin
    next_state  = state;
    pc_mux_sel  = 1'b0;
    jmp_loc     = jmp_loc_q;
    stall       = 1'b0;
    stall_pm    = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    do_redirect = 1'b0;
    do_capture  = 1'b0;
    do_timeout  = 1'b0;
    if (boot_q) begin
      // PC is still loading the reset vector; the fetched word is not valid.
      pc_mux_sel = 1'b1;
      jmp_loc    = RESET_VECTOR;
    end else begin
      case (state)
        ST_RUN: begin
          if (ext_stall) begin
            stall    = 1'b1;
            stall_pm = 1'b1;
          end else if (dec_is_jump) begin
            pc_mux_sel  = 1'b1;
            jmp_loc     = dec_target;
            do_redirect = 1'b1;
            next_state  = ST_FLUSH;
          end else if (dec_is_branch) begin
            stall      = 1'b1;
            stall_pm   = 1'b1;
            do_capture = 1'b1;
            next_state = ST_BR_WAIT;
          end else if (dec_is_halt) begin
            stall      = 1'b1;
            stall_pm   = 1'b1;
            next_state = ST_HALT;
          end
        end
        ST_BR_WAIT: begin
          stall    = 1'b1;
          stall_pm = 1'b1;
          if (br_resolved && br_taken) begin
            // PM output stays frozen; the wrong-path word is flushed next cycle.
            stall       = 1'b0;
            pc_mux_sel  = 1'b1;
            jmp_loc     = br_target_q;
            do_redirect = 1'b1;
            next_state  = ST_FLUSH;
          end else if (br_resolved) begin
            stall      = 1'b0;
            stall_pm   = 1'b0;
            next_state = ST_RUN;
          end else if (to_cnt_q == TO_W'(BR_TIMEOUT - 1)) begin
            // Last allowed wait cycle with no result: fall through as not-taken.
            stall      = 1'b0;
            stall_pm   = 1'b0;
            do_timeout = 1'b1;
            next_state = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush      = 1'b1;
          next_state = ST_RUN;
        end
        ST_HALT: begin
          halted   = 1'b1;
          stall    = 1'b1;
          stall_pm = 1'b1;
          if (run) next_state = ST_RUN;
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_RUN;
      boot_q         <= 1'b1;
      jmp_loc_q      <= RESET_VECTOR;
      br_target_q    <= 16'h0000;
      to_cnt_q       <= '0;
      err_q          <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      boot_q    <= 1'b0;
      state     <= next_state;
      jmp_loc_q <= jmp_loc;
      if (do_capture) begin
        br_target_q <= dec_target;
        to_cnt_q    <= '0;
      end else if (state == ST_BR_WAIT && !boot_q) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (do_timeout) err_q <= 1'b1;
      if (do_redirect && (redirect_cnt_q != {CNT_W{1'b1}}))
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
    end
  end

  assign br_timeout_err = err_q;
  assign redirect_cnt   = redirect_cnt_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_pm_fetch_controller.sv
// Bench for pm_fetch_controller: directed scenarios followed by random
// instruction/handshake stimulus, checked every cycle against a behavioural
// model built from flags and counters. A second instance with a 4-bit
// redirect counter exercises saturation in a reachable number of cycles.
module tb_pm_fetch_controller;

  localparam logic [5:0] M_J = 6'h02, M_JAL = 6'h03, M_BEQ = 6'h04, M_BNE = 6'h05, M_HLT = 6'h3F;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        ext_stall, br_resolved, br_taken, run;
  logic [15:0] jmp_loc, jmp_loc_s;
  logic        pc_mux_sel, stall, stall_pm, flush, halted, br_timeout_err;
  logic        pc_mux_sel_s, stall_s, stall_pm_s, flush_s, halted_s, br_timeout_err_s;
  logic [15:0] redirect_cnt;
  logic [3:0]  redirect_cnt_s;
  logic [1:0]  state_dbg, state_dbg_s;

  pm_fetch_controller dut (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .ext_stall(ext_stall), .br_resolved(br_resolved), .br_taken(br_taken), .run(run),
    .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .stall(stall), .stall_pm(stall_pm),
    .flush(flush), .halted(halted), .br_timeout_err(br_timeout_err),
    .redirect_cnt(redirect_cnt), .state_dbg(state_dbg)
  );

  pm_fetch_controller #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .ext_stall(ext_stall), .br_resolved(br_resolved), .br_taken(br_taken), .run(run),
    .jmp_loc(jmp_loc_s), .pc_mux_sel(pc_mux_sel_s), .stall(stall_s), .stall_pm(stall_pm_s),
    .flush(flush_s), .halted(halted_s), .br_timeout_err(br_timeout_err_s),
    .redirect_cnt(redirect_cnt_s), .state_dbg(state_dbg_s)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];   // predicted redirect targets, consumed when the DUT redirects

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_boot, m_wait, m_flush, m_halt, m_err;
  int          m_wait_n;      // completed cycles spent waiting on the branch
  logic [15:0] m_target, m_last;
  int          m_cnt;

  task automatic model_reset();
    m_boot = 1; m_wait = 0; m_flush = 0; m_halt = 0; m_err = 0;
    m_wait_n = 0; m_target = 16'h0; m_last = 16'h0; m_cnt = 0;
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge: drive, check just after, then let one rising edge pass.
  task automatic step(input logic [31:0] i, input logic [15:0] a,
                      input logic es, input logic br, input logic bt, input logic rn);
    logic [5:0]  op;
    logic [15:0] imm;
    logic        e_pc, e_st, e_spm, e_fl, e_h;
    logic [15:0] e_jl;
    ins = i; current_address = a; ext_stall = es; br_resolved = br; br_taken = bt; run = rn;
    op  = i[31:26];
    imm = i[15:0];
    #1;
    e_pc = 0; e_st = 0; e_spm = 0; e_fl = 0; e_h = 0; e_jl = m_last;
    if (m_boot) begin
      e_pc = 1; e_jl = 16'h0000;
    end else if (m_flush) begin
      e_fl = 1;
    end else if (m_halt) begin
      e_h = 1; e_st = 1; e_spm = 1;
    end else if (m_wait) begin
      e_st = 1; e_spm = 1;
      if (br && bt) begin e_st = 0; e_pc = 1; e_jl = m_target; end
      else if (br) begin e_st = 0; e_spm = 0; end
      else if (m_wait_n == 7) begin e_st = 0; e_spm = 0; end
    end else begin
      if (es) begin e_st = 1; e_spm = 1; end
      else if (op == M_J || op == M_JAL) begin e_pc = 1; e_jl = imm; end
      else if (op == M_BEQ || op == M_BNE || op == M_HLT) begin e_st = 1; e_spm = 1; end
    end
    if (e_pc && !m_boot) exp_q.push_back(e_jl);

    check_val("pc_mux_sel", pc_mux_sel, e_pc);
    check_val("jmp_loc", jmp_loc, e_jl);
    check_val("stall", stall, e_st);
    check_val("stall_pm", stall_pm, e_spm);
    check_val("flush", flush, e_fl);
    check_val("halted", halted, e_h);
    check_val("br_timeout_err", br_timeout_err, m_err);
    check_val("redirect_cnt", redirect_cnt, m_cnt);
    check_val("redirect_cnt_sat4", redirect_cnt_s, sat15(m_cnt));
    if (pc_mux_sel && !m_boot) begin
      if (exp_q.size() > 0) check_val("redirect_target", jmp_loc, exp_q.pop_front());
      else check_val("redirect_unexpected", pc_mux_sel, 0);
    end

    @(posedge clk);
    if (m_boot) begin
      m_boot = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_halt) begin
      if (rn) m_halt = 0;
    end else if (m_wait) begin
      if (br && bt) begin
        m_wait = 0; m_flush = 1; m_last = m_target;
        if (m_cnt < 65535) m_cnt++;
      end else if (br) begin
        m_wait = 0;
      end else if (m_wait_n == 7) begin
        m_wait = 0; m_err = 1;
      end
      m_wait_n++;
    end else if (!es) begin
      if (op == M_J || op == M_JAL) begin
        m_flush = 1; m_last = imm;
        if (m_cnt < 65535) m_cnt++;
      end else if (op == M_BEQ || op == M_BNE) begin
        m_wait = 1; m_wait_n = 0; m_target = a + 16'd1 + imm;
      end else if (op == M_HLT) begin
        m_halt = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(NOP, 16'h0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must return immediately.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check_val("rst_pc_mux_sel", pc_mux_sel, 1);
    check_val("rst_jmp_loc", jmp_loc, 16'h0000);
    check_val("rst_stall", stall, 0);
    check_val("rst_stall_pm", stall_pm, 0);
    check_val("rst_flush", flush, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_err", br_timeout_err, 0);
    check_val("rst_cnt", redirect_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  logic [31:0] rnd;
  logic [5:0]  rop;

  initial begin
    reset = 1'b0; ins = NOP; current_address = 16'h0;
    ext_stall = 0; br_resolved = 0; br_taken = 0; run = 0;
    model_reset();
    #11;
    check_val("rst_pc_mux_sel", pc_mux_sel, 1);
    check_val("rst_jmp_loc", jmp_loc, 16'h0000);
    check_val("rst_stall", stall, 0);
    check_val("rst_stall_pm", stall_pm, 0);
    check_val("rst_flush", flush, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_err", br_timeout_err, 0);
    check_val("rst_cnt", redirect_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // Jump
    step(32'h0800_0040, 16'h0005, 0, 0, 0, 0);
    idle(2);
    // Taken branch, resolved on the second wait cycle
    step(32'h1000_0003, 16'h0010, 0, 0, 0, 0);
    step(NOP, 16'h0, 0, 0, 0, 0);
    step(NOP, 16'h0, 0, 1, 1, 0);
    idle(2);
    // Not-taken branch, resolved on the first wait cycle
    step(32'h1400_0007, 16'h0020, 0, 0, 0, 0);
    step(NOP, 16'h0, 0, 1, 0, 0);
    idle(1);
    // Branch with no resolve: timeout
    step(32'h1000_0009, 16'h0030, 0, 0, 0, 0);
    idle(10);
    // Halt, stray run ignored outside HALT, then run pulse
    step(NOP, 16'h0, 0, 0, 0, 1);
    step(32'hFC00_0000, 16'h0040, 0, 0, 0, 0);
    idle(3);
    step(NOP, 16'h0, 0, 0, 0, 1);
    idle(1);
    // ext_stall with a J present
    step(32'h0800_0123, 16'h0050, 1, 0, 0, 0);
    step(32'h0C00_0456, 16'h0050, 1, 0, 0, 0);
    idle(1);
    // Branch target wraps past 16'hFFFF
    step(32'h1000_0005, 16'hFFFE, 0, 0, 0, 0);
    step(NOP, 16'h0, 0, 1, 1, 0);
    idle(1);
    // Reset during BR_WAIT and during HALT
    step(32'h1000_0011, 16'h0060, 0, 0, 0, 0);
    step(NOP, 16'h0, 0, 0, 0, 0);
    apply_reset();
    idle(2);
    step(32'hFC00_0000, 16'h0070, 0, 0, 0, 0);
    idle(1);
    apply_reset();
    idle(2);
    // Drive the 4-bit counter into saturation
    for (int k = 0; k < 20; k++) begin
      rnd = $urandom();
      step({M_J, 10'h0, rnd[15:0]}, rnd[31:16], 0, 0, 0, 0);
      idle(1);
    end

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rnd = $urandom();
      case ($urandom_range(0, 9))
        0: rop = M_J;
        1: rop = M_JAL;
        2: rop = M_BEQ;
        3: rop = M_BNE;
        4: rop = ($urandom_range(0, 2) == 0) ? M_HLT : 6'h00;
        default: begin
          rop = 6'($urandom_range(0, 63));
          if (rop inside {M_J, M_JAL, M_BEQ, M_BNE, M_HLT}) rop = 6'h08;
        end
      endcase
      step({rop, rnd[25:0]}, 16'($urandom()),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    check_val("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
